cross_clock_handshake_rx: RTL

Destination-side receiver of the toggle-based request/acknowledge clock-domain-crossing protocol. It synchronizes an asynchronous request toggle into `CLK` and captures the source-held data bus. It presents the word to a local consumer with a valid/ready handshake, then returns an acknowledge toggle to the source domain. It sits at the `CLK` edge of any multi-bit crossing where a free-running double-buffer is unsafe because bus bits may be skewed.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/sync_stages.sv | 34 +++
 rtl/cross_clock_handshake_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared definitions for the toggle request/acknowledge crossing
package cdc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } cdc_state_e;

  localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_stages.sv
// rtl/sync_stages.sv - reset-to-zero flop chain for a single-bit asynchronous input
module sync_stages #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_stages: STAGES must be at least 2");
    end
  endgenerate

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], D};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign Q = chain_q[STAGES-1];

endmodule

// File: rtl/cross_clock_handshake_rx.sv
// rtl/cross_clock_handshake_rx.sv - destination side of the toggle handshake crossing
module cross_clock_handshake_rx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic                   REQ_TOGGLE,
  input  logic [DATA_WIDTH-1:0]  DATA_IN,
  input  logic                   DATA_READY,
  output logic [DATA_WIDTH-1:0]  DATA_OUT,
  output logic                   DATA_VALID,
  output logic                   ACK_TOGGLE,
  output logic                   OVERRUN,
  output logic [COUNT_WIDTH-1:0] XFER_COUNT
);

  generate
    if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
      $error("cross_clock_handshake_rx: SYNC_STAGES below minimum");
    end
  endgenerate

  cdc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_last_q, req_last_d;
  logic                  ack_q, ack_d;
  logic                  overrun_q, overrun_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                  req_s;
  logic                  req_edge;

  sync_stages #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (REQ_TOGGLE),
    .Q       (req_s)
  );

  assign req_edge = req_s ^ req_last_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    req_last_d = req_last_q;
    ack_d      = ack_q;
    overrun_d  = overrun_q;
    count_d    = count_q;
    unique case (state_q)
      ST_IDLE: begin
        // With ENABLE low req_last stays put, so the edge is held pending.
        if (req_edge && ENABLE) begin
          data_d     = DATA_IN;
          req_last_d = req_s;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        // A second toggle before the ack is flagged but still consumed later.
        if (req_edge) begin
          overrun_d = 1'b1;
        end
        if (DATA_READY) begin
          ack_d   = ~ack_q;
          count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      req_last_q <= 1'b0;
      ack_q      <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      req_last_q <= req_last_d;
      ack_q      <= ack_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = (state_q == ST_VALID);
  assign ACK_TOGGLE = ack_q;
  assign OVERRUN    = overrun_q;
  assign XFER_COUNT = count_q;

endmodule
